// File: rtl/load_store_unit_if.sv
// load_store_unit_if: bus bundle between the pipeline, the load/store unit and data memory.
// Request side  : req_valid/req_ready handshake with req_we, req_size, req_unsigned, req_addr, req_wdata.
// Response side : resp_valid one-cycle pulse with resp_rdata and resp_err.
// Memory side   : mem_addr (word aligned), mem_byte_enable, mem_wdata out; mem_rdata combinational in.
// Modports      : slave is the load/store unit, master is the pipeline plus data memory.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_byte_enable, mem_wdata
    );
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_byte_enable, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores against a word-wide, combinational-read data memory.
// Ports: clk, rst (asynchronous, active high) and bus (load_store_unit_if.slave) carrying the
// request handshake, the one-cycle response pulse and the word-aligned memory port.
// Build option LSU_MISALIGN_EN: when defined, accesses crossing a word boundary are split into two
// memory cycles (ACC0, ACC1); when undefined, misaligned requests answer at once with resp_err.
module load_store_unit (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);
`ifdef LSU_MISALIGN_EN
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACC0, RESP} state_t;
`endif
    state_t      state, state_nx;
    logic        we_q, uns_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, word0;
    logic        hs, err;
    logic [1:0]  off;
    logic [4:0]  sh;
    logic [3:0]  mask;
    logic [31:0] base, raw, ext;
`ifdef LSU_MISALIGN_EN
    logic [31:0] word1;
    logic        cross;
    logic [7:0]  smask;
    logic [63:0] sdata;
`else
    logic [3:0]  smask;
    logic [31:0] sdata;
`endif

    assign hs   = bus.req_valid && state == IDLE;
    assign off  = addr_q[1:0];
    assign sh   = {off, 3'b000};
    assign base = {addr_q[31:2], 2'b00};
    // Reserved size 3 behaves as a word everywhere.
    assign mask = size_q == 2'd0 ? 4'b0001 : size_q == 2'd1 ? 4'b0011 : 4'b1111;

`ifdef LSU_MISALIGN_EN
    assign err   = 1'b0;
    // Offset plus access length beyond four bytes spills into the next word.
    assign cross = ({1'b0, off} + (size_q == 2'd0 ? 3'd1 : size_q == 2'd1 ? 3'd2 : 3'd4)) > 3'd4;
    assign smask = {4'b0000, mask} << off;
    assign sdata = {32'h0, wdata_q} << sh;
    assign raw   = 32'({word1, word0} >> sh);
`else
    // Without splitting, a half must sit on an even address and a word on a multiple of four.
    assign err   = bus.req_size == 2'd0 ? 1'b0 : bus.req_size == 2'd1 ? bus.req_addr[0] : |bus.req_addr[1:0];
    assign smask = mask << off;
    assign sdata = wdata_q << sh;
    assign raw   = word0 >> sh;
`endif

    assign ext = size_q == 2'd0 ? {{24{raw[7] & ~uns_q}}, raw[7:0]} :
                 size_q == 2'd1 ? {{16{raw[15] & ~uns_q}}, raw[15:0]} : raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (hs) state_nx = err ? RESP : ACC0;
`ifdef LSU_MISALIGN_EN
            ACC0: state_nx = cross ? ACC1 : RESP;
            ACC1: state_nx = RESP;
`else
            ACC0: state_nx = RESP;
`endif
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            word0   <= 32'h0;
`ifdef LSU_MISALIGN_EN
            word1   <= 32'h0;
`endif
        end else begin
            if (hs) begin
                we_q    <= bus.req_we;
                uns_q   <= bus.req_unsigned;
                err_q   <= err;
                size_q  <= bus.req_size;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (state == ACC0) word0 <= bus.mem_rdata;
`ifdef LSU_MISALIGN_EN
            if (state == ACC1) word1 <= bus.mem_rdata;
`endif
        end
    end

    always_comb begin
        bus.req_ready       = state == IDLE;
        bus.resp_valid      = state == RESP;
        bus.resp_err        = state == RESP && err_q;
        bus.resp_rdata      = (state == RESP && !we_q && !err_q) ? ext : 32'h0;
        bus.mem_addr        = 32'h0;
        bus.mem_byte_enable = 4'b0000;
        bus.mem_wdata       = 32'h0;
        if (state == ACC0) begin
            bus.mem_addr        = base;
            bus.mem_byte_enable = we_q ? smask[3:0] : 4'b0000;
            bus.mem_wdata       = we_q ? sdata[31:0] : 32'h0;
        end
`ifdef LSU_MISALIGN_EN
        if (state == ACC1) begin
            bus.mem_addr        = base + 32'd4;
            bus.mem_byte_enable = we_q ? smask[7:4] : 4'b0000;
            bus.mem_wdata       = we_q ? sdata[63:32] : 32'h0;
        end
`endif
    end
endmodule
